// File: rtl/jump_lut_loader.sv
// Programmable 2^IDX_W-entry branch-target table loaded from a valid/ready byte stream.
// Build option: define JUMP_LUT_BOOT_EN to have reset load the boot target set instead of zeros.
module jump_lut_loader #(
    parameter int IDX_W = 5,
    parameter int TGT_W = 10
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             In_valid,
    input  logic [7:0]       In_data,
    output logic             In_ready,
    input  logic [IDX_W-1:0] addr,
    output logic [TGT_W-1:0] Target,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int CW    = IDX_W + 1;

    typedef enum logic [2:0] {IDLE, HDR, LO, HI, FIN} state_t;

    state_t           state_q;
    logic [CW-1:0]    wp_q;
    logic [CW-1:0]    rem_q;
    logic [7:0]       lo_q;
    logic             err_q;
    logic [TGT_W-1:0] tbl_q [DEPTH];

    logic             accept;
    logic [5:0]       hdr_cnt;
    logic             hdr_bad;
    logic [TGT_W-1:0] entry_d;

    function automatic logic [TGT_W-1:0] reset_val(input int idx);
        case (idx)
`ifdef JUMP_LUT_BOOT_EN
            0:       return TGT_W'(11);
            1:       return TGT_W'(179);
            2:       return TGT_W'(314);
            3:       return TGT_W'(318);
            4:       return TGT_W'(341);
            5:       return TGT_W'(337);
            30:      return TGT_W'(322);
            31:      return TGT_W'(345);
`endif
            default: return '0;
        endcase
    endfunction

    assign Busy     = (state_q == HDR) || (state_q == LO) || (state_q == HI);
    assign In_ready = Busy;
    assign Done     = (state_q == FIN);
    assign Err      = err_q;
    assign Target   = tbl_q[addr];

    assign accept   = In_valid && In_ready;
    assign hdr_cnt  = In_data[5:0];
    assign hdr_bad  = (hdr_cnt == 6'd0) || (int'(hdr_cnt) > DEPTH);
    // High byte contributes only the bits above the low byte; its upper bits are dropped.
    assign entry_d  = {In_data[TGT_W-9:0], lo_q};

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            wp_q    <= '0;
            rem_q   <= '0;
            lo_q    <= '0;
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= reset_val(i);
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_q <= HDR;
                        err_q   <= 1'b0;
                        wp_q    <= '0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        if (hdr_bad) begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            rem_q   <= CW'(hdr_cnt);
                            state_q <= LO;
                        end
                    end
                end
                LO: begin
                    if (accept) begin
                        lo_q    <= In_data;
                        state_q <= HI;
                    end
                end
                HI: begin
                    if (accept) begin
                        tbl_q[wp_q[IDX_W-1:0]] <= entry_d;
                        wp_q    <= wp_q + CW'(1);
                        rem_q   <= rem_q - CW'(1);
                        state_q <= (rem_q == CW'(1)) ? FIN : LO;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jump_lut_loader.sv
// Directed bench for jump_lut_loader: table contents checked through a scoreboard queue.
module tb_jump_lut_loader;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0;
    logic       In_valid = 1'b0;
    logic [7:0] In_data = 8'h00;
    logic       In_ready;
    logic [4:0] addr = 5'd0;
    logic [9:0] Target;
    logic       Busy;
    logic       Done;
    logic       Err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = -1;
    int exp_done = 0;
    int start_cyc = 0;
    int exp_tbl [32];

    typedef struct {
        int idx;
        int val;
    } sb_t;
    sb_t sb_q[$];

    jump_lut_loader #(.IDX_W(5), .TGT_W(10)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .In_valid(In_valid),
        .In_data(In_data), .In_ready(In_ready), .addr(addr), .Target(Target),
        .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;
    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) exp_tbl[i] = 0;
`ifdef JUMP_LUT_BOOT_EN
        exp_tbl[0] = 11;  exp_tbl[1] = 179; exp_tbl[2] = 314; exp_tbl[3] = 318;
        exp_tbl[4] = 341; exp_tbl[5] = 337; exp_tbl[30] = 322; exp_tbl[31] = 345;
`endif
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        In_valid = 1'b1;
        In_data  = b;
        while (In_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(In_ready), 32'd1);
        tick();
        In_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        In_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start();
        start_cyc = cyc;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic push_all();
        for (int i = 0; i < 32; i++) sb_q.push_back('{i, exp_tbl[i]});
    endtask

    task automatic drain(input string tag);
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            addr = 5'(e.idx);
            tick();
            chk($sformatf("%s_tbl%0d", tag, e.idx), 32'(Target), 32'(e.val));
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input logic err_exp);
        chk({tag, "_ready"}, 32'(In_ready), 32'd0);
        chk({tag, "_busy"},  32'(Busy),     32'd0);
        chk({tag, "_done"},  32'(Done),     32'd0);
        chk({tag, "_err"},   32'(Err),      32'(err_exp));
    endtask

    initial begin
        int v;

        // Reset and reset-state table contents
        model_reset();
        Reset_n = 1'b0;
        tick(); tick();
        chk_idle_outputs("rst", 1'b0);
        Reset_n = 1'b1;
        tick();
        chk_idle_outputs("rst_rel", 1'b0);
        push_all();
        drain("rst");

        // Two-entry back-to-back load with latency and write-visibility checks
        do_start();
        chk("s2_busy", 32'(Busy), 32'd1);
        send(8'h02);
        send(8'h0B); send(8'h00);
        addr = 5'd1;
        send(8'hB3);
        send(8'h01);
        chk("s2_wr_visible", 32'(Target), 32'd435);
        chk("s2_done", 32'(Done), 32'd1);
        chk("s2_busy_fall", 32'(Busy), 32'd0);
        chk("s2_ready_fin", 32'(In_ready), 32'd0);
        tick();
        exp_done++;
        chk("s2_done_pulse", 32'(Done), 32'd0);
        chk("s2_latency", 32'(last_done_cyc - start_cyc), 32'd6);
        exp_tbl[0] = 11;
        exp_tbl[1] = 435;
        push_all();
        drain("s2");

        // Zero-count header
        do_start();
        send(8'h00);
        chk_idle_outputs("h0", 1'b1);
        gap(4);
        chk("h0_sticky", 32'(Err), 32'd1);
        chk("h0_nodone", 32'(done_cnt), 32'(exp_done));
        do_start();
        chk("h0_clear", 32'(Err), 32'd0);

        // Over-range count 33 (start already accepted above)
        send(8'h21);
        chk_idle_outputs("h33", 1'b1);
        gap(3);
        chk("h33_nodone", 32'(done_cnt), 32'(exp_done));
        push_all();
        drain("h33");

        // Full 32-entry load with random valid gaps
        chk("full_ready_idle", 32'(In_ready), 32'd0);
        do_start();
        chk("full_err_clr", 32'(Err), 32'd0);
        send(8'h20);
        for (int k = 0; k < 32; k++) begin
            v = k * 31;
            gap($urandom_range(0, 2));
            send(8'(v));
            gap($urandom_range(0, 2));
            send(8'(v >> 8));
            exp_tbl[k] = v;
        end
        chk("full_done", 32'(Done), 32'd1);
        chk("full_ready_fin", 32'(In_ready), 32'd0);
        tick();
        exp_done++;
        chk("full_done_cnt", 32'(done_cnt), 32'(exp_done));
        push_all();
        drain("full");

        // Reset in the middle of a five-entry load
        do_start();
        send(8'h05);
        for (int k = 0; k < 3; k++) begin
            send(8'(100 + k));
            send(8'h02);
        end
        send(8'h55);
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        model_reset();
        chk_idle_outputs("mid_rst", 1'b0);
        gap(4);
        chk("mid_rst_nodone", 32'(done_cnt), 32'(exp_done));
        push_all();
        drain("mid_rst");

        // Byte driven in IDLE and Start pulsed while busy are both ignored
        In_valid = 1'b1;
        In_data  = 8'h03;
        tick(); tick();
        chk("idle_byte_ready", 32'(In_ready), 32'd0);
        chk("idle_byte_busy", 32'(Busy), 32'd0);
        In_valid = 1'b0;
        tick();
        do_start();
        send(8'h02);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("start_busy_ign", 32'(Busy), 32'd1);
        send(8'h22); send(8'h01);
        Start = 1'b1;
        send(8'h07);
        Start = 1'b0;
        send(8'h03);
        chk("ign_done", 32'(Done), 32'd1);
        tick();
        exp_done++;
        chk("ign_err", 32'(Err), 32'd0);
        chk("ign_done_cnt", 32'(done_cnt), 32'(exp_done));
        exp_tbl[0] = 290;
        exp_tbl[1] = 775;
        push_all();
        drain("ign");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jump_lut_loader.md
# jump_lut_loader

Programmable branch-target table with a byte-stream write port. Replaces the fixed 32-entry jump target lookup. A boot/debug source streams 10-bit targets into the table over a valid/ready byte interface, and the fetch stage reads them combinationally by 5-bit index. It sits between the boot loader and the program-counter update logic.

## Interface
Parameters:
- IDX_W, 5, index width; table depth = 2^IDX_W = 32
- TGT_W, 10, target width; must satisfy 8 < TGT_W <= 16

Ports:
- Clk  input  1  clock; all state updates on its rising edge
- Reset_n  input  1  synchronous reset, active-low
- Start  input  1  begin a load session; sampled only in IDLE
- In_valid  input  1  In_data holds a byte
- In_data  input  8  stream byte
- In_ready  output  1  loader accepts a byte this cycle
- addr  input  IDX_W  lookup index
- Target  output  TGT_W  table[addr], combinational from registers
- Busy  output  1  load session active
- Done  output  1  one-cycle pulse when a load completes
- Err  output  1  sticky error flag, cleared by the next accepted Start

## Operation
- Byte transfer: a byte is accepted on a cycle with In_valid && In_ready.
- Stream format:
  - One header byte. count = In_data[5:0]; valid range is 1..32; In_data[7:6] are ignored.
  - Then count entries. Each entry is a low byte (target[7:0]) followed by a high byte (target[TGT_W-1:8] taken from the low bits; the remaining bits are ignored).
- FSM states: IDLE, HDR, LO, HI, FIN.
  - IDLE: In_ready=0. On Start, go to HDR, clear Err, and reset the write pointer wp to 0.
  - HDR: In_ready=1. On an accepted byte, if count is 0 or greater than 32: set Err and go to IDLE with no writes. Otherwise latch remaining=count and go to LO.
  - LO: In_ready=1. On an accepted byte, latch the low byte and go to HI.
  - HI: In_ready=1. On an accepted byte, write table[wp] = {hi, lo}, increment wp, decrement remaining. If remaining was 1, go to FIN; otherwise go to LO.
  - FIN: In_ready=0 and Done=1 for this cycle; go to IDLE.
- Busy = 1 in HDR, LO and HI.
- Entries at index >= count keep their previous contents.
- wp never wraps, because count <= 32.
- Start is ignored outside IDLE. Bytes presented in IDLE or FIN are not accepted.
- Lookup is always live, including during a load.

## Timing
- Reset (Reset_n low at a clock edge), applied on that edge:
  - State goes to IDLE.
  - In_ready=0, Busy=0, Done=0, Err=0, wp=0.
  - All table entries take their reset values (see Configuration).
- Reset mid-load aborts the session: there is no Done, entries written before the reset are also restored to reset values, and the partial entry is discarded.
- Write latency: a HI byte accepted at edge N updates table[wp] at edge N. Target for that index shows the new value from that edge onward, one cycle after the byte was presented.
- Done asserts in the cycle after the final HI byte is accepted.
- Minimum session length with back-to-back bytes is 2 + 2·count cycles from Start to Done: 1 cycle into HDR, 1 header byte, 2·count entry bytes, then FIN.
- A gap in In_valid stalls the FSM in its current state, with no timeout.
- Err, once set in HDR, holds until a Start is accepted in IDLE.

## Configuration
- Macro JUMP_LUT_BOOT_EN.
- Defined: reset loads the boot target set:
  - index 0=11, 1=179, 2=314, 3=318, 4=341, 5=337
  - index 30=322, 31=345
  - all other entries 0
  - The core can branch before any load session.
- Undefined: reset clears every entry to 0, and the table must be loaded before use.
- The FSM and stream protocol are identical in both builds.

## Test plan
- Reset with JUMP_LUT_BOOT_EN defined, then read addr=1 and addr=31 -> Target=179 and 345. Without the macro, both read 0.
- Start, then bytes 0x02, 0x0B,0x00, 0xB3,0x01 back-to-back -> table[0]=11 and table[1]=435. Done pulses exactly 6 cycles after Start, Busy falls in the same cycle, and table[2] is unchanged.
- Header 0x00, and separately header 0x21 (count 33) -> Err=1, no table change, no Done, return to IDLE. The next Start clears Err.
- Full load of 32 entries, where entry k = k·31 (max 961), with random In_valid gaps -> every index reads back correctly, and In_ready is 0 in IDLE and FIN.
- Reset_n low after 3 of 5 entries are written -> all outputs return to reset values, the table holds reset contents, and no Done is seen.
- Start pulsed during Busy and a byte driven in IDLE -> both ignored, and the session completes normally with the expected contents.
